// File: rtl/match_counter.sv
// Programmable terminal-count sequencer: latches a target on start, counts en ticks,
// flags count == target (match) and pulses done when the terminal tick is consumed.
module match_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             wrap_mode,
  input  logic             en,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] count,
  output logic             match,
  output logic             done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] target_reg;
  logic             mode_reg;
  logic             done_reg;
  logic             at_target;

  assign at_target = (count_reg == target_reg);

  // Priority: clear, then start, then en; done is a single-cycle pulse by default.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      target_reg <= '0;
      mode_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (clear) begin
        state_reg <= IDLE;
        count_reg <= '0;
      end else if (start) begin
        target_reg <= target;
        mode_reg   <= wrap_mode;
        count_reg  <= '0;
        state_reg  <= RUN;
      end else if (state_reg == RUN && en) begin
        if (at_target) begin
          done_reg  <= 1'b1;
          count_reg <= '0;
          if (!mode_reg) begin
            state_reg <= IDLE;
          end
        end else begin
          count_reg <= count_reg + 1'b1;
        end
      end
    end
  end

  // Decoded from registers only, so no input reaches match combinationally.
  assign busy  = (state_reg == RUN);
  assign match = busy && at_target;
  assign count = count_reg;
  assign done  = done_reg;

endmodule
